// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing for a 50 MHz / 115200 baud link.
package uart_pkg;

    localparam int UART_SYS_CLK_HZ    = 50_000_000;
    localparam int UART_BAUD          = 115_200;
    localparam int UART_OVERSAMPLE    = 16;
    localparam int UART_CLKS_PER_TICK = UART_SYS_CLK_HZ / (UART_BAUD * UART_OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every CLKS_PER_TICK clocks, with a sync clear for phase alignment.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = (cnt_q == CNT_LAST) && !clr;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 8N1 by default, single-entry holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | confirming the start bit at its midpoint
// DATA   | sampling data bits mid-bit, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, offering the byte to the holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK,
    parameter int OVERSAMPLE    = UART_OVERSAMPLE,
    parameter int DATA_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_meta, rx_s, rx_d;
    logic tick, tick_clr;

    uart_state_e           state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  frame_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d, par_mismatch;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        tick_clr     = 1'b0;
        frame_ok     = 1'b0;
        stop_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        par_mismatch = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Requires a high-to-low transition, so a held break never retriggers.
                if (rx_d && !rx_s) begin
                    tick_clr   = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        par_mismatch = (rx_s != ^shreg_q);
                        par_bad_d    = par_mismatch;
                        state_d      = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        stop_bad   = !rx_s;
`ifdef UART_RX_PARITY_EN
                        frame_ok   = rx_s && !par_bad_q;
`else
                        frame_ok   = rx_s;
`endif
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_mismatch;
`endif
            if (frame_ok) begin
                // A drain in the same cycle frees the slot, so the new byte replaces the old one.
                if (!data_valid || data_ready) begin
                    data_out   <= shreg_q;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table of frames plus hand-written corner sequences, scoreboard on the handshake.
module tb_uart_rx;

    localparam int CPT      = 4;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BIT_CLKS = CPT * OS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          data_ready = 1'b0;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
    logic          par_flip = 1'b0;
    int            perr_cnt = 0;
`endif

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (OS),
        .DATA_BITS    (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int rise_cyc = 0;
    int edge_cyc = 0;
    logic dv_prev = 1'b0;
    logic [DB-1:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_good;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        rx = 1'b0;
        edge_cyc = cyc;
        hold(BIT_CLKS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            hold(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        hold(BIT_CLKS);
`endif
        rx = stop_b;
        hold(BIT_CLKS);
        rx = 1'b1;
        hold(16);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) perr_cnt++;
`endif
            if (data_valid && !dv_prev) rise_cyc = cyc;
            if (data_valid && data_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte actual=%0h required=none", data_out);
                end else begin
                    check("rx_byte", int'(data_out), int'(sb.pop_front()));
                end
            end
            dv_prev = data_valid;
        end else begin
            dv_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   f0, o0, lat;
        vecs[0] = '{8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'h5A, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1};

        hold(3);
        check("rst_data_out", int'(data_out), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        hold(10);

        data_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (vecs[i].exp_good) sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit);
            check("vec_frame_err", ferr_cnt - f0, vecs[i].exp_good ? 0 : 1);
            check("vec_overrun", ovr_cnt - o0, 0);
            check("vec_drained", sb.size(), 0);
            check("vec_valid_low", int'(data_valid), 0);
            if (i == 0) begin
                lat = rise_cyc - edge_cyc;
                total++;
                if (lat < 604 || lat > 616) begin
                    bad++;
                    $display("FAIL start_to_valid actual=%0d required=604..616", lat);
                end
            end
        end

        // false start: short low pulse
        rx = 1'b0;
        hold(20);
        check("false_start_busy_high", int'(busy), 1);
        rx = 1'b1;
        hold(40);
        check("false_start_busy_low", int'(busy), 0);
        check("false_start_no_valid", int'(data_valid), 0);

        // overrun with consumer stalled
        data_ready = 1'b0;
        o0 = ovr_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("overrun_pulse", ovr_cnt - o0, 1);
        check("overrun_valid_held", int'(data_valid), 1);
        check("overrun_old_byte", int'(data_out), 'h11);
        data_ready = 1'b1;
        hold(1);
        check("drain_valid_falls", int'(data_valid), 0);
        check("drain_scoreboard", sb.size(), 0);

        // reset mid-frame with a full holding register
        data_ready = 1'b0;
        send_frame(8'h44, 1'b1);
        check("preload_valid", int'(data_valid), 1);
        check("preload_byte", int'(data_out), 'h44);
        rx = 1'b0;
        hold(BIT_CLKS);
        rx = 1'b1;
        hold(3 * BIT_CLKS);
        check("mid_frame_busy", int'(busy), 1);
        reset = 1'b0;
        hold(3);
        check("mid_rst_data_out", int'(data_out), 0);
        check("mid_rst_data_valid", int'(data_valid), 0);
        check("mid_rst_frame_err", int'(frame_err), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_busy", int'(busy), 0);
        sb.delete();
        reset = 1'b1;
        hold(20);
        data_ready = 1'b1;
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("post_rst_drained", sb.size(), 0);

`ifdef UART_RX_PARITY_EN
        f0 = perr_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        check("parity_bad_pulse", perr_cnt - f0, 1);
        check("parity_bad_no_valid", int'(data_valid), 0);
        f0 = perr_cnt;
        par_flip = 1'b0;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        check("parity_good_no_pulse", perr_cnt - f0, 0);
        check("parity_good_drained", sb.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
